// File: rtl/i2c_master_arbiter_if.sv
// Purpose: bundles the client request/response signals and the I2C master
//          command/status signals used by i2c_master_arbiter.
// Modports:
//   master - arbiter view: samples requests and master status, drives grants,
//            completions and master commands.
//   slave  - environment view: the requesters plus the I2C master datapath.
// Signals:
//   req/req_addr/req_rw/req_wdata  per-requester request level and payload
//   gnt/done/err                   one-hot grant, completion pulse, error flag
//   rdata                          read byte returned with done
//   m_start/m_addr/m_rw/m_wdata    command to the I2C master
//   m_busy/m_done/m_rdata/m_error  status from the I2C master
interface i2c_master_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req;
  logic [7*NUM_REQ-1:0] req_addr;
  logic [NUM_REQ-1:0]   req_rw;
  logic [8*NUM_REQ-1:0] req_wdata;
  logic [NUM_REQ-1:0]   gnt;
  logic [NUM_REQ-1:0]   done;
  logic [NUM_REQ-1:0]   err;
  logic [7:0]           rdata;
  logic                 m_start;
  logic [6:0]           m_addr;
  logic                 m_rw;
  logic [7:0]           m_wdata;
  logic                 m_busy;
  logic                 m_done;
  logic [7:0]           m_rdata;
  logic                 m_error;

  modport master (
    input  req, req_addr, req_rw, req_wdata,
    input  m_busy, m_done, m_rdata, m_error,
    output gnt, done, err, rdata,
    output m_start, m_addr, m_rw, m_wdata
  );

  modport slave (
    output req, req_addr, req_rw, req_wdata,
    output m_busy, m_done, m_rdata, m_error,
    input  gnt, done, err, rdata,
    input  m_start, m_addr, m_rw, m_wdata
  );
endinterface

// File: rtl/i2c_master_arbiter.sv
// Purpose: shares one I2C master between NUM_REQ requesters, one single-byte
//          transaction at a time, with round-robin arbitration and a WAIT
//          timeout. Results go back to the granted requester only.
// Ports:
//   i_clk           system clock
//   i_rst           synchronous reset, active-high
//   io_arb          request/response and master command/status bundle
//   o_timeout_flag  sticky timeout indicator, cleared only by reset
// NUM_REQ must match the NUM_REQ of the connected interface instance.
module i2c_master_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TIMEOUT = 4096,
  parameter int unsigned CNT_W   = 13
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  i2c_master_arbiter_if.master io_arb,
  output logic                 o_timeout_flag
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0]  PTR_RST  = IDX_W'(NUM_REQ - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_ISSUE,
    S_WAIT,
    S_COMPLETE
  } state_t;

  state_t               r_state;
  logic [IDX_W-1:0]     r_ptr;
  logic [IDX_W-1:0]     r_win;
  logic [CNT_W-1:0]     r_cnt;
  logic [NUM_REQ-1:0]   r_gnt;
  logic [NUM_REQ-1:0]   r_done;
  logic [NUM_REQ-1:0]   r_err;
  logic [7:0]           r_rdata;
  logic                 r_m_start;
  logic [6:0]           r_m_addr;
  logic                 r_m_rw;
  logic [7:0]           r_m_wdata;
  logic                 r_tflag;

  logic                 w_any;
  logic [IDX_W-1:0]     w_win;
  logic [NUM_REQ-1:0]   w_win_oh;
  int unsigned          w_idx;

  // Round-robin pick: first set request scanning upward from r_ptr+1, wrapping.
  always_comb begin
    w_any    = 1'b0;
    w_win    = '0;
    w_win_oh = '0;
    w_idx    = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      w_idx = 32'(r_ptr) + i;
      if (w_idx >= NUM_REQ) begin
        w_idx = w_idx - NUM_REQ;
      end
      if (!w_any && io_arb.req[w_idx[IDX_W-1:0]]) begin
        w_any = 1'b1;
        w_win = w_idx[IDX_W-1:0];
      end
    end
    w_win_oh[w_win] = w_any;
  end

  // Grant and payload latch are loaded on the IDLE->GRANT edge so that the
  // registered gnt/m_* outputs are already valid during the GRANT cycle.
  // done/err are likewise loaded on entry to COMPLETE.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_ptr     <= PTR_RST;
      r_win     <= '0;
      r_cnt     <= '0;
      r_gnt     <= '0;
      r_done    <= '0;
      r_err     <= '0;
      r_rdata   <= '0;
      r_m_start <= 1'b0;
      r_m_addr  <= '0;
      r_m_rw    <= 1'b0;
      r_m_wdata <= '0;
      r_tflag   <= 1'b0;
    end else begin
      r_m_start <= 1'b0;
      r_done    <= '0;
      r_err     <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_win     <= w_win;
            r_gnt     <= w_win_oh;
            r_m_addr  <= io_arb.req_addr[7*w_win +: 7];
            r_m_rw    <= io_arb.req_rw[w_win];
            r_m_wdata <= io_arb.req_wdata[8*w_win +: 8];
            r_state   <= S_GRANT;
          end
        end
        S_GRANT: begin
          r_cnt   <= '0;
          r_state <= S_ISSUE;
        end
        S_ISSUE: begin
          if (!io_arb.m_busy) begin
            r_m_start <= 1'b1;
            r_state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          // A completion in the timeout cycle takes precedence over the timeout.
          if (io_arb.m_done) begin
            r_done  <= r_gnt;
            r_err   <= io_arb.m_error ? r_gnt : '0;
            if (r_m_rw) begin
              r_rdata <= io_arb.m_rdata;
            end
            r_state <= S_COMPLETE;
          end else if (r_cnt == CNT_LAST) begin
            r_done  <= r_gnt;
            r_err   <= r_gnt;
            r_tflag <= 1'b1;
            r_state <= S_COMPLETE;
          end
        end
        S_COMPLETE: begin
          r_gnt   <= '0;
          r_ptr   <= r_win;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign io_arb.gnt     = r_gnt;
  assign io_arb.done    = r_done;
  assign io_arb.err     = r_err;
  assign io_arb.rdata   = r_rdata;
  assign io_arb.m_start = r_m_start;
  assign io_arb.m_addr  = r_m_addr;
  assign io_arb.m_rw    = r_m_rw;
  assign io_arb.m_wdata = r_m_wdata;
  assign o_timeout_flag = r_tflag;

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Purpose: self-checking bench for i2c_master_arbiter. Acts as the requesters
//          and the I2C master; a transaction-level model predicts the winner,
//          latencies, done/err, rdata and the sticky timeout flag.
module tb_i2c_master_arbiter;
  localparam int NUM_REQ = 4;
  localparam int TIMEOUT = 64;

  logic clk;
  logic rst;
  logic tflag;

  i2c_master_arbiter_if #(.NUM_REQ(NUM_REQ)) bif ();

  i2c_master_arbiter #(
    .NUM_REQ (NUM_REQ),
    .TIMEOUT (TIMEOUT),
    .CNT_W   (8)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .io_arb         (bif),
    .o_timeout_flag (tflag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_tests = 0;
  int n_fail  = 0;

  logic [NUM_REQ-1:0] cur_req;
  logic [6:0]         a_addr [NUM_REQ];
  logic               a_rw   [NUM_REQ];
  logic [7:0]         a_wd   [NUM_REQ];
  int                 m_ptr;
  logic [7:0]         exp_rdata;
  logic               exp_flag;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int rr_pick(input logic [NUM_REQ-1:0] r, input int p);
    for (int k = 1; k <= NUM_REQ; k++) begin
      int idx;
      idx = (p + k) % NUM_REQ;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic drive();
    for (int i = 0; i < NUM_REQ; i++) begin
      bif.req_addr[7*i +: 7]  = a_addr[i];
      bif.req_rw[i]           = a_rw[i];
      bif.req_wdata[8*i +: 8] = a_wd[i];
    end
    bif.req = cur_req;
  endtask

  task automatic set_req(input int i, input logic [6:0] ad, input logic rw, input logic [7:0] wd);
    a_addr[i]  = ad;
    a_rw[i]    = rw;
    a_wd[i]    = wd;
    cur_req[i] = 1'b1;
  endtask

  // Entered just after a negedge whose following posedge is an IDLE sample.
  // Returns at the negedge after the done cycle, with the same property.
  task automatic txn(input int busy, input int dly, input logic [7:0] rd, input logic merr,
                     input bit spurious, input bit keep, input bit drop_early);
    int w, t, u, exp_start, exp_u;
    bit found, got, is_to;
    logic [NUM_REQ-1:0] oh;
    w = rr_pick(cur_req, m_ptr);
    if (w < 0) begin
      check("req_present", 32'(cur_req), 32'h1);
      return;
    end
    oh = '0;
    oh[w] = 1'b1;
    if (busy > 0) bif.m_busy = 1'b1;
    @(negedge clk);
    check("gnt", 32'(bif.gnt), 32'(oh));
    check("m_addr", 32'(bif.m_addr), 32'(a_addr[w]));
    check("m_rw", 32'(bif.m_rw), 32'(a_rw[w]));
    check("m_wdata", 32'(bif.m_wdata), 32'(a_wd[w]));
    if (drop_early) begin
      cur_req[w] = 1'b0;
      drive();
    end
    if (spurious) begin
      bif.m_done  = 1'b1;
      bif.m_rdata = 8'hEE;
      bif.m_error = 1'b1;
    end
    t = 0;
    found = 1'b0;
    while (!found && t < busy + 4) begin
      @(negedge clk);
      t++;
      if (t == 1) begin
        bif.m_done  = 1'b0;
        bif.m_error = 1'b0;
      end
      if (t == busy) bif.m_busy = 1'b0;
      if (bif.m_start) found = 1'b1;
    end
    bif.m_busy = 1'b0;
    exp_start = ((busy > 1) ? busy : 1) + 1;
    check("start_seen", 32'(found), 32'h1);
    check("start_lat", 32'(t), 32'(exp_start));
    if (dly >= 0 && dly <= TIMEOUT - 1) begin
      exp_u = dly + 1;
      is_to = 1'b0;
    end else begin
      exp_u = TIMEOUT;
      is_to = 1'b1;
    end
    u = 0;
    got = 1'b0;
    while (!got && u <= TIMEOUT + 4) begin
      if (dly >= 0 && u == dly) begin
        bif.m_done  = 1'b1;
        bif.m_rdata = rd;
        bif.m_error = merr;
      end else begin
        bif.m_done  = 1'b0;
        bif.m_rdata = 8'($urandom);
        bif.m_error = 1'($urandom);
      end
      @(negedge clk);
      u++;
      if (u == 1) check("m_start_1cyc", 32'(bif.m_start), 32'h0);
      if (bif.done != '0) got = 1'b1;
    end
    bif.m_done  = 1'b0;
    bif.m_error = 1'b0;
    if (!is_to && a_rw[w]) exp_rdata = rd;
    if (is_to) exp_flag = 1'b1;
    check("done_seen", 32'(got), 32'h1);
    check("done_lat", 32'(u), 32'(exp_u));
    check("done", 32'(bif.done), 32'(oh));
    check("err", 32'(bif.err), (is_to || merr) ? 32'(oh) : 32'h0);
    check("rdata", 32'(bif.rdata), 32'(exp_rdata));
    check("tflag", 32'(tflag), 32'(exp_flag));
    check("gnt_hold", 32'(bif.gnt), 32'(oh));
    check("m_addr_hold", 32'(bif.m_addr), 32'(a_addr[w]));
    m_ptr = w;
    if (!keep) begin
      cur_req[w] = 1'b0;
      drive();
    end
    @(negedge clk);
    check("done_1cyc", 32'(bif.done), 32'h0);
    check("gnt_clr", 32'(bif.gnt), 32'h0);
  endtask

  initial begin
    bit seen;
    cur_req = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      a_addr[i] = '0;
      a_rw[i]   = 1'b0;
      a_wd[i]   = '0;
    end
    drive();
    bif.m_busy  = 1'b0;
    bif.m_done  = 1'b0;
    bif.m_rdata = '0;
    bif.m_error = 1'b0;
    m_ptr     = NUM_REQ - 1;
    exp_rdata = '0;
    exp_flag  = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_gnt", 32'(bif.gnt), 32'h0);
    check("rst_done", 32'(bif.done), 32'h0);
    check("rst_err", 32'(bif.err), 32'h0);
    check("rst_rdata", 32'(bif.rdata), 32'h0);
    check("rst_m_start", 32'(bif.m_start), 32'h0);
    check("rst_m_addr", 32'(bif.m_addr), 32'h0);
    check("rst_m_wdata", 32'(bif.m_wdata), 32'h0);
    check("rst_m_rw", 32'(bif.m_rw), 32'h0);
    check("rst_tflag", 32'(tflag), 32'h0);
    rst = 1'b0;

    // Single write from requester 0, completion on the third WAIT cycle.
    set_req(0, 7'h4B, 1'b0, 8'hA5);
    drive();
    txn(0, 2, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    // All four held: round-robin rotation, requests stay high after done.
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 7'($urandom), 1'($urandom), 8'($urandom));
    drive();
    for (int k = 0; k < 5; k++) txn(0, k % 3, 8'($urandom), 1'b0, 1'b0, 1'b1, 1'b0);
    cur_req = '0;

    // Read with master error from requester 2.
    set_req(2, 7'h21, 1'b1, 8'h00);
    drive();
    txn(0, 1, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);

    // Master busy at ISSUE for 10 cycles, plus a stray m_done outside WAIT.
    set_req(0, 7'h12, 1'b1, 8'h77);
    drive();
    txn(10, 0, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0);

    // m_done coincides with the last timeout cycle: completion wins.
    set_req(3, 7'h7F, 1'b1, 8'h00);
    drive();
    txn(0, TIMEOUT - 1, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0);

    // No m_done at all: timeout error, sticky flag.
    set_req(1, 7'h08, 1'b1, 8'h00);
    drive();
    txn(0, -1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    // Randomized traffic.
    for (int k = 0; k < 40; k++) begin
      int busy, dly;
      bit keep, drop;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!cur_req[i] && ($urandom_range(0, 1) == 1))
          set_req(i, 7'($urandom), 1'($urandom), 8'($urandom));
      end
      if (cur_req == '0) set_req(int'($urandom_range(0, NUM_REQ - 1)), 7'($urandom), 1'($urandom), 8'($urandom));
      drive();
      busy = int'($urandom_range(0, 3));
      dly  = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 6));
      keep = ($urandom_range(0, 3) == 0);
      drop = !keep && ($urandom_range(0, 4) == 0);
      txn(busy, dly, 8'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0), keep, drop);
    end

    // Reset in the middle of WAIT: silent abort, then a normal grant.
    cur_req = '0;
    set_req(0, 7'h33, 1'b0, 8'h44);
    drive();
    seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      @(negedge clk);
      if (bif.m_start) seen = 1'b1;
    end
    check("t6_start", 32'(seen), 32'h1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    cur_req = '0;
    drive();
    @(negedge clk);
    rst = 1'b0;
    check("t6_gnt", 32'(bif.gnt), 32'h0);
    check("t6_done", 32'(bif.done), 32'h0);
    check("t6_err", 32'(bif.err), 32'h0);
    check("t6_m_start", 32'(bif.m_start), 32'h0);
    check("t6_m_addr", 32'(bif.m_addr), 32'h0);
    check("t6_rdata", 32'(bif.rdata), 32'h0);
    check("t6_tflag", 32'(tflag), 32'h0);
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bif.done != '0) seen = 1'b1;
    end
    check("t6_no_done", 32'(seen), 32'h0);
    m_ptr     = NUM_REQ - 1;
    exp_rdata = '0;
    exp_flag  = 1'b0;
    set_req(1, 7'h55, 1'b1, 8'h00);
    drive();
    txn(0, 3, 8'h99, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
